// File: rtl/shift_add_mult_n.sv
// Sequential shift-add multiplier with unsigned/signed modes: one FSM drives
// the accumulator, so the M (acc LSB) and K (last bit) qualifiers are internal.
module shift_add_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_st,
  input  logic                 i_sgn,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_idle,
  output logic                 o_load,
  output logic                 o_ad,
  output logic                 o_sh,
  output logic                 o_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_SHIFT = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] mag;
    if (sgn && v[WIDTH-1]) begin
      mag = ~v + WIDTH'(1);
    end else begin
      mag = v;
    end
    return mag;
  endfunction

  state_t               r_state;
  logic [2*WIDTH:0]     r_acc;
  logic [WIDTH-1:0]     r_mc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic                 r_idle;
  logic                 r_load;
  logic                 r_done;

  logic                 w_m;
  logic                 w_k;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_acc_shr;
  logic [2*WIDTH-1:0]   w_acc_neg;
  logic [CW-1:0]        w_cnt_nxt;

  assign w_m       = r_acc[0];
  assign w_k       = (r_cnt == CNT_LAST);
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mc};
  assign w_acc_shr = {1'b0, r_acc[2*WIDTH:1]};
  assign w_acc_neg = ~r_acc[2*WIDTH-1:0] + (2*WIDTH)'(1);
  // Counter wraps to zero on the last shift, also for non-power-of-two widths.
  assign w_cnt_nxt = w_k ? CW'(0) : (r_cnt + CW'(1));

  // Controller and datapath; Idle/Load/Done are registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mc    <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_idle  <= 1'b1;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_st) begin
            r_state <= S_LOAD;
            r_idle  <= 1'b0;
            r_load  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_acc   <= {1'b0, {WIDTH{1'b0}}, magnitude(i_mplier, i_sgn)};
          r_mc    <= magnitude(i_mcand, i_sgn);
          r_cnt   <= CW'(0);
          r_neg   <= i_sgn & (i_mcand[WIDTH-1] ^ i_mplier[WIDTH-1]);
          r_state <= S_TEST;
          r_load  <= 1'b0;
        end
        S_TEST: begin
          if (w_m) begin
            r_acc[2*WIDTH:WIDTH] <= w_sum;
            r_state              <= S_SHIFT;
          end else begin
            r_acc   <= w_acc_shr;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_k ? S_FIX : S_TEST;
          end
        end
        S_SHIFT: begin
          r_acc   <= w_acc_shr;
          r_cnt   <= w_cnt_nxt;
          r_state <= w_k ? S_FIX : S_TEST;
        end
        S_FIX: begin
          if (r_neg) begin
            r_acc[2*WIDTH-1:0] <= w_acc_neg;
          end
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          if (!i_st) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
          r_load  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Ad/Sh depend on the accumulator LSB in TEST, so they cannot be registered.
  always_comb begin
    o_ad = 1'b0;
    o_sh = 1'b0;
    case (r_state)
      S_TEST: begin
        o_ad = w_m;
        o_sh = ~w_m;
      end
      S_SHIFT: begin
        o_sh = 1'b1;
      end
      default: begin
        o_ad = 1'b0;
        o_sh = 1'b0;
      end
    endcase
  end

  assign o_product = r_acc[2*WIDTH-1:0];
  assign o_idle    = r_idle;
  assign o_load    = r_load;
  assign o_done    = r_done;

endmodule

// File: tb/tb_shift_add_mult_n.sv
// Bench for shift_add_mult_n at WIDTH=8 and WIDTH=16 against an arithmetic reference.
module tb_shift_add_mult_n;

  logic        clk;
  logic        rst_n;
  logic        st8;
  logic        st16;
  logic        sgn;
  logic [15:0] mc;
  logic [15:0] mp;
  logic [15:0] p8;
  logic [31:0] p16;
  logic        idle8, load8, ad8, sh8, done8;
  logic        idle16, load16, ad16, sh16, done16;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_mult_n #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_st(st8), .i_sgn(sgn),
    .i_mcand(mc[7:0]), .i_mplier(mp[7:0]), .o_product(p8),
    .o_idle(idle8), .o_load(load8), .o_ad(ad8), .o_sh(sh8), .o_done(done8)
  );

  shift_add_mult_n #(.WIDTH(16)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_st(st16), .i_sgn(sgn),
    .i_mcand(mc), .i_mplier(mp), .o_product(p16),
    .o_idle(idle16), .o_load(load16), .o_ad(ad16), .o_sh(sh16), .o_done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int w, output logic idle, output logic load, output logic ad,
                        output logic sh, output logic done, output logic [31:0] prod);
    if (w == 16) begin
      idle = idle16; load = load16; ad = ad16; sh = sh16; done = done16; prod = p16;
    end else begin
      idle = idle8; load = load8; ad = ad8; sh = sh8; done = done8; prod = {16'h0000, p8};
    end
  endtask

  task automatic set_st(input int w, input logic v);
    if (w == 16) st16 = v;
    else st8 = v;
  endtask

  // Runs one multiplication from an idle DUT; called #1 after a rising edge.
  task automatic run_op(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input bit hold, input bit perturb, output logic [31:0] exp_out);
    longint av, bv, mag, expv, mask, one;
    int p, cyc, adc, shc;
    bit seen;
    logic idle, load, ad, sh, done;
    logic [31:0] prod;
    one  = 1;
    mask = (one << (2 * w)) - 1;
    if (w == 16) begin
      av = s ? longint'($signed(a)) : longint'(a);
      bv = s ? longint'($signed(b)) : longint'(b);
    end else begin
      av = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      bv = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end
    mag = (bv < 0) ? -bv : bv;
    p = 0;
    for (int k = 0; k < 17; k++) p += int'((mag >> k) & 64'd1);
    expv    = (av * bv) & mask;
    exp_out = 32'(expv);

    sgn = s; mc = a; mp = b;
    set_st(w, 1'b1);
    cyc = 0; adc = 0; shc = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && !hold) set_st(w, 1'b0);
      if (perturb && cyc == 3) begin
        mc = 16'($urandom); mp = 16'($urandom); sgn = ~sgn;
      end
      sample(w, idle, load, ad, sh, done, prod);
      if (done) seen = 1;
      else begin
        adc += int'(ad);
        shc += int'(sh);
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(3 + w + p));
    check("product", 64'(prod), 64'(expv));
    check("ad_cycles", 64'(adc), 64'(p));
    check("sh_cycles", 64'(shc), 64'(w));
    if (!hold) begin
      @(posedge clk); #1;
      sample(w, idle, load, ad, sh, done, prod);
      check("idle_after_done", {idle, load, ad, sh, done}, 5'b10000);
      check("product_held", 64'(prod), 64'(expv));
    end
  endtask

  initial begin : main
    logic idle, load, ad, sh, done;
    logic [31:0] prod, expv, expv2;
    int cyc, shc;

    // Reset with random St
    rst_n = 1'b0; st8 = 1'b0; st16 = 1'b0; sgn = 1'b0; mc = 16'h0; mp = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      st8 = 1'($urandom_range(0, 1)); st16 = 1'($urandom_range(0, 1));
      sample(8, idle, load, ad, sh, done, prod);
      check("rst_ctl8", {idle, load, ad, sh, done}, 5'b10000);
      check("rst_prod8", 64'(prod), 64'd0);
    end
    sample(16, idle, load, ad, sh, done, prod);
    check("rst_ctl16", {idle, load, ad, sh, done}, 5'b10000);
    check("rst_prod16", 64'(prod), 64'd0);
    st8 = 1'b0; st16 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample(8, idle, load, ad, sh, done, prod);
    check("idle_after_rst", {idle, load, ad, sh, done}, 5'b10000);

    // Directed unsigned cases
    run_op(8, 1'b0, 16'd13, 16'd11, 0, 0, expv);
    check("13x11", 64'(expv), 64'd143);
    run_op(8, 1'b0, 16'd255, 16'd0, 0, 0, expv);
    check("255x0", 64'(expv), 64'd0);
    run_op(8, 1'b0, 16'd255, 16'd255, 0, 0, expv);
    check("255x255", 64'(expv), 64'd65025);

    // Directed signed cases; the first one scrambles operands after LOAD
    run_op(8, 1'b1, 16'h0007, 16'h00FD, 0, 1, expv);
    check("7xm3", 64'(expv), 64'h0000FFEB);
    run_op(8, 1'b1, 16'h0080, 16'h0080, 0, 0, expv);
    check("m128xm128", 64'(expv), 64'h00004000);
    run_op(8, 1'b1, 16'h00FF, 16'h007F, 0, 0, expv);
    check("m1x127", 64'(expv), 64'h0000FF81);

    // St held high through DONE
    run_op(8, 1'b0, 16'd200, 16'd77, 1, 0, expv);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sample(8, idle, load, ad, sh, done, prod);
      check("hold_done", 64'(done), 64'd1);
      check("hold_prod", 64'(prod), 64'(expv));
    end
    st8 = 1'b0;
    @(posedge clk); #1;
    sample(8, idle, load, ad, sh, done, prod);
    check("drop_st_idle", {idle, load, ad, sh, done}, 5'b10000);
    @(posedge clk); #1;
    sample(8, idle, load, ad, sh, done, prod);
    check("no_restart", {idle, load, ad, sh, done}, 5'b10000);
    run_op(8, 1'b1, 16'h00C3, 16'h005A, 0, 0, expv2);

    // Reset four shifts into an operation
    sgn = 1'b0; mc = 16'h00FF; mp = 16'h00FF; st8 = 1'b1;
    cyc = 0; shc = 0;
    while (cyc < 60 && shc < 4) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) st8 = 1'b0;
      sample(8, idle, load, ad, sh, done, prod);
      shc += int'(sh);
    end
    check("reached_4_shifts", 64'(shc), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    sample(8, idle, load, ad, sh, done, prod);
    check("midop_rst_ctl", {idle, load, ad, sh, done}, 5'b10000);
    check("midop_rst_prod", 64'(prod), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random operations at both widths
    for (int i = 0; i < 100; i++) begin
      run_op(8, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 0, 0, expv);
      run_op(16, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 0, 0, expv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
